// File: rtl/icache_ctrl.sv
// icache_ctrl: miss/fill sequencer for a 2-way, 64-set instruction cache with 8 x 16-bit words per block.
// Optional ICACHE_HIT_LRU_EN: hits on the non-MRU way refresh both ways' LRU bits.
module icache_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        tag_out0,
    input  logic [7:0]        tag_out1,
    input  logic [15:0]       mem_data,
    input  logic              mem_data_valid,
    output logic              hit,
    output logic              stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              data_wrt_en,
    output logic              tag_wrt_en,
    output logic              way0,
    output logic              way1,
    output logic [7:0]        tag_in,
    output logic [15:0]       data_in,
    output logic [63:0]       blk_en,
    output logic [7:0]        word_enable,
    output logic              fill_done
);

    if (ADDR_W != 16 || WORDS != 8 || MEM_LAT < 1) begin : g_cfg_check
        $error("icache_ctrl: unsupported configuration");
    end

    localparam logic [3:0] WORDS_C = 4'(WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_TAG_NEW, S_TAG_OLD, S_DONE, S_HIT_A, S_HIT_B
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  issue_cnt_q, issue_cnt_d;
    logic [3:0]  rcv_cnt_q, rcv_cnt_d;
    logic [5:0]  tag_q, tag_d;
    logic [5:0]  set_q, set_d;
    logic        victim_q, victim_d;
    logic [6:0]  other_meta_q, other_meta_d;
    logic        mem_rd_en_q, mem_rd_en_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        tag_wrt_en_q, tag_wrt_en_d;
    logic        tag_way_q, tag_way_d;
    logic [7:0]  tag_in_q, tag_in_d;
    logic        fill_done_q, fill_done_d;

    logic [5:0]  req_tag, req_set, blk_set;
    logic        hit0, hit1, hit_any, miss_victim, rcv_ok;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[3:0];

    always_comb begin
        req_tag = req_addr[15:10];
        req_set = req_addr[9:4];
        hit0    = tag_out0[6] && (tag_out0[5:0] == req_tag);
        hit1    = tag_out1[6] && (tag_out1[5:0] == req_tag);
        hit_any = req_valid && (hit0 || hit1);
        // Prefer an empty way, then the LRU way; a tie falls back to way0.
        if (!tag_out0[6])                   miss_victim = 1'b0;
        else if (!tag_out1[6])              miss_victim = 1'b1;
        else if (tag_out0[7] != tag_out1[7]) miss_victim = tag_out1[7];
        else                                miss_victim = 1'b0;
    end

    always_comb begin
        rcv_ok      = (state_q == S_FILL) && mem_data_valid && (rcv_cnt_q < WORDS_C);
        hit         = (state_q == S_IDLE) && hit_any;
        stall       = (state_q != S_IDLE) || (req_valid && !hit_any);
        data_wrt_en = rcv_ok;
        word_enable = rcv_ok ? (8'd1 << rcv_cnt_q[2:0]) : 8'd0;
        data_in     = mem_data;
        way1        = tag_wrt_en_q ? tag_way_q  : (rcv_ok && victim_q);
        way0        = tag_wrt_en_q ? !tag_way_q : (rcv_ok && !victim_q);
        blk_set     = (state_q == S_IDLE) ? req_set : set_q;
        blk_en      = 64'd1 << blk_set;
        mem_rd_en   = mem_rd_en_q;
        mem_addr    = mem_addr_q;
        tag_wrt_en  = tag_wrt_en_q;
        tag_in      = tag_in_q;
        fill_done   = fill_done_q;
    end

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        tag_d        = tag_q;
        set_d        = set_q;
        victim_d     = victim_q;
        other_meta_d = other_meta_q;
        mem_rd_en_d  = 1'b0;
        mem_addr_d   = 16'd0;
        tag_wrt_en_d = 1'b0;
        tag_way_d    = 1'b0;
        tag_in_d     = 8'd0;
        fill_done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !hit_any) begin
                    state_d      = S_FILL;
                    tag_d        = req_tag;
                    set_d        = req_set;
                    victim_d     = miss_victim;
                    other_meta_d = miss_victim ? tag_out0[6:0] : tag_out1[6:0];
                    rcv_cnt_d    = 4'd0;
                    issue_cnt_d  = 4'd1;
                    mem_rd_en_d  = 1'b1;
                    mem_addr_d   = {req_tag, req_set, 3'd0, 1'b0};
                    // Invalidate the victim so a partially filled line can never hit.
                    tag_wrt_en_d = 1'b1;
                    tag_way_d    = miss_victim;
                    tag_in_d     = {2'b00, miss_victim ? tag_out1[5:0] : tag_out0[5:0]};
                end
`ifdef ICACHE_HIT_LRU_EN
                else if (hit_any && (hit0 ? tag_out0[7] : tag_out1[7])) begin
                    state_d      = S_HIT_A;
                    set_d        = req_set;
                    victim_d     = !hit0;
                    other_meta_d = hit0 ? tag_out1[6:0] : tag_out0[6:0];
                    tag_wrt_en_d = 1'b1;
                    tag_way_d    = !hit0;
                    tag_in_d     = {1'b0, hit0 ? tag_out0[6:0] : tag_out1[6:0]};
                end
`endif
            end
            S_FILL: begin
                if (rcv_ok) rcv_cnt_d = rcv_cnt_q + 4'd1;
                if (rcv_cnt_d == WORDS_C) begin
                    state_d      = S_TAG_NEW;
                    tag_wrt_en_d = 1'b1;
                    tag_way_d    = victim_q;
                    tag_in_d     = {2'b01, tag_q};
                end else if (issue_cnt_q < WORDS_C) begin
                    mem_rd_en_d  = 1'b1;
                    mem_addr_d   = {tag_q, set_q, issue_cnt_q[2:0], 1'b0};
                    issue_cnt_d  = issue_cnt_q + 4'd1;
                end
            end
            S_TAG_NEW: begin
                state_d      = S_TAG_OLD;
                tag_wrt_en_d = 1'b1;
                tag_way_d    = !victim_q;
                tag_in_d     = {1'b1, other_meta_q};
            end
            S_TAG_OLD: begin
                state_d     = S_DONE;
                fill_done_d = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            S_HIT_A: begin
                state_d      = S_HIT_B;
                tag_wrt_en_d = 1'b1;
                tag_way_d    = !victim_q;
                tag_in_d     = {1'b1, other_meta_q};
            end
            S_HIT_B: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            issue_cnt_q  <= 4'd0;
            rcv_cnt_q    <= 4'd0;
            tag_q        <= 6'd0;
            set_q        <= 6'd0;
            victim_q     <= 1'b0;
            other_meta_q <= 7'd0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= 16'd0;
            tag_wrt_en_q <= 1'b0;
            tag_way_q    <= 1'b0;
            tag_in_q     <= 8'd0;
            fill_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            tag_q        <= tag_d;
            set_q        <= set_d;
            victim_q     <= victim_d;
            other_meta_q <= other_meta_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            tag_wrt_en_q <= tag_wrt_en_d;
            tag_way_q    <= tag_way_d;
            tag_in_q     <= tag_in_d;
            fill_done_q  <= fill_done_d;
        end
    end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Miss/fill sequencer for the 2-way, 64-set instruction cache (8 x 16-bit words per block, 8-bit metadata per way).
- Performs hit detection from the metadata read-out and picks a victim way using valid/LRU bits.
- Streams 8 words from the pipelined 4-cycle memory into the data array, then writes metadata.
- Sits between the fetch stage (stall) and the cache arrays plus the memory read port.

Parameters:
ADDR_W, 16, byte address width; tag = addr[15:10], set = addr[9:4], word = addr[3:1]
WORDS, 8, words per block; sets issue and receive count limit
MEM_LAT, 4, memory read latency in cycles; bench and documentation only, controller counts returned beats

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  fetch request; held stable with req_addr while stall=1
req_addr  in  16  fetch byte address
tag_out0  in  8  way0 metadata for set selected by blk_en: [7]=LRU, [6]=valid, [5:0]=tag
tag_out1  in  8  way1 metadata, same format
mem_data  in  16  memory read data
mem_data_valid  in  1  mem_data valid; in order, one beat per issued read
hit  out  1  combinational: req_valid and a valid way tag-matches, state IDLE
stall  out  1  req_valid & ~hit in IDLE, or state != IDLE
mem_rd_en  out  1  memory read issue
mem_addr  out  16  {tag, set, issue_cnt[2:0], 1'b0}
data_wrt_en  out  1  data array write
tag_wrt_en  out  1  metadata write
way0  out  1  way select; exactly one of way0/way1 high when any write asserted
way1  out  1  way select
tag_in  out  8  metadata write value
data_in  out  16  data array write value (= mem_data)
blk_en  out  64  one-hot set select
word_enable  out  8  one-hot word select
fill_done  out  1  one-cycle pulse at end of fill

Behaviour:
- Reset: state IDLE, counters 0, latched address 0, every registered output 0. blk_en = onehot(req_addr[9:4]).
- IDLE: blk_en decodes req_addr set.
  - Hit = valid & tag == req_addr[15:10] on either way.
  - Hit: no writes, stall=0.
  - Miss: latch addr[15:4]; go FILL next cycle.
- Victim: way0 if way0 invalid; else way1 if way1 invalid; else the way whose LRU bit = 1; if both LRU bits equal, way0. Latched on the miss cycle.
- FILL, first cycle: tag_wrt_en=1 to victim with tag_in = {1'b0, 1'b0, old tag}. This invalidates the line before any data write.
- FILL, issue: issue_cnt 0..7, one mem_rd_en per cycle for 8 consecutive cycles. Word order is 0..7 regardless of requested word.
- FILL, receive: each mem_data_valid beat writes data_wrt_en=1 with word_enable = onehot(rcv_cnt), victim way, then increments rcv_cnt.
- Issue and receive overlap. Exit FILL when rcv_cnt reaches 8. Beats beyond 8, or received outside FILL, are ignored.
- TAG_NEW (1 cycle): write victim metadata {LRU=0, valid=1, latched tag}.
- TAG_OLD (1 cycle): write the other way {LRU=1, its valid, its tag} from tag_out captured at miss.
- DONE (1 cycle): fill_done=1, then IDLE. The re-lookup hits.
- Timing, miss detected at cycle T:
  - invalidate T+1;
  - issues T+1..T+8;
  - data T+5..T+12 (MEM_LAT=4);
  - TAG_NEW T+13, TAG_OLD T+14, DONE T+15;
  - hit at T+16.
- blk_en uses the latched set in every non-IDLE state. req_addr changes outside IDLE are ignored.
- Reset mid-operation: immediate IDLE, all writes and mem_rd_en drop. The victim line is already invalid, so a partial fill is never hit.

Optional Feature:
- ICACHE_HIT_LRU_EN defined: a hit, when not already MRU (hit-way LRU=1), enters HIT_A then HIT_B. These write the hit way with LRU=0 and the other way with LRU=1 (same tag/valid). stall=1 for those 2 cycles, then IDLE.
- Not defined: hits never write, stall=0; LRU changes only on fill.

Test Plan:
- Reset, req 0x0000 on empty cache -> stall=1, invalidate, 8 mem_rd_en addrs 0x0000..0x000E, 8 data writes word_enable 0x01..0x80 way0, TAG_NEW tag_in 0x40, fill_done at T+15, hit at T+16.
- Second miss same set (0x0400) -> victim way1, TAG_NEW 0x41 to way1, TAG_OLD 0xC0 to way0; third miss 0x0800 -> victim way0.
- mem_data_valid with 2-cycle gaps between beats -> 8 writes still in order, FILL extends; extra 9th beat ignored.
- Assert rst at FILL rcv_cnt=3 -> all outputs 0 next edge, IDLE; same request misses again and refills.
- With ICACHE_HIT_LRU_EN: hit way0 while way0 LRU=1 -> 2-cycle stall, writes 0x40|tag to way0, 0xC0|tag to way1; without the macro, same hit gives stall=0 and no writes.
